// File: rtl/hdmi_video_pkg.sv
// Shared types, constants and pixel packing helper for the HDMI output stage.
package hdmi_video_pkg;

    localparam int unsigned SLOT_WIDTH = 12;
    localparam int unsigned DATA_WIDTH = 3 * SLOT_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_e;

    // MSB-align a zero-extended component inside its 12-bit slot.
    function automatic logic [SLOT_WIDTH-1:0] pack_slot(
        input logic [SLOT_WIDTH-1:0] comp,
        input int unsigned           comp_width
    );
        return comp << (SLOT_WIDTH - comp_width);
    endfunction

endpackage

// File: rtl/hdmi_timing_axis.sv
// One timing axis: position counter, latched region lengths and region decode.
module hdmi_timing_axis
    import hdmi_video_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         advance,
    input  logic [W-1:0] len_active,
    input  logic [W-1:0] len_fp,
    input  logic [W-1:0] len_sync,
    input  logic [W-1:0] len_bp,
    output logic [W-1:0] cnt,
    output logic [1:0]   region_c,
    output logic         last_c
);

    logic [W-1:0] act_q, act_d;
    logic [W-1:0] fp_q, fp_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] bp_q, bp_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] fp_end, sync_end, bp_end;

    // Region boundaries, decode, wrap detection and next counter value.
    always_comb begin
        fp_end   = act_q + fp_q + W'(1);
        sync_end = fp_end + sync_q + W'(1);
        bp_end   = sync_end + bp_q + W'(1);

        if (cnt_q <= act_q)         region_c = ACTIVE;
        else if (cnt_q <= fp_end)   region_c = FP;
        else if (cnt_q <= sync_end) region_c = SYNC;
        else                        region_c = BP;

        last_c = (cnt_q == bp_end);

        act_d  = load ? len_active : act_q;
        fp_d   = load ? len_fp     : fp_q;
        sync_d = load ? len_sync   : sync_q;
        bp_d   = load ? len_bp     : bp_q;

        cnt_d = cnt_q;
        if (clr)          cnt_d = '0;
        else if (advance) cnt_d = last_c ? '0 : cnt_q + W'(1);
    end

    // Counter and latched lengths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q  <= '0;
            fp_q   <= '0;
            sync_q <= '0;
            bp_q   <= '0;
            cnt_q  <= '0;
        end else begin
            act_q  <= act_d;
            fp_q   <= fp_d;
            sync_q <= sync_d;
            bp_q   <= bp_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hdmi_video_out.sv
// HDMI pixel output stage: run/drain control, timing generation and pixel sink.
module hdmi_video_out
    import hdmi_video_pkg::*;
#(
    parameter int unsigned COMP_WIDTH = 8,
    parameter int unsigned H_WIDTH    = 12,
    parameter int unsigned V_WIDTH    = 12
) (
    input  logic                    ACLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic [H_WIDTH-1:0]      H_ACTIVE,
    input  logic [H_WIDTH-1:0]      H_FP,
    input  logic [H_WIDTH-1:0]      H_SYNC,
    input  logic [H_WIDTH-1:0]      H_BP,
    input  logic [V_WIDTH-1:0]      V_ACTIVE,
    input  logic [V_WIDTH-1:0]      V_FP,
    input  logic [V_WIDTH-1:0]      V_SYNC,
    input  logic [V_WIDTH-1:0]      V_BP,
    input  logic                    HSYNC_POL,
    input  logic                    VSYNC_POL,
    input  logic [3*COMP_WIDTH-1:0] PIX_DATA,
    input  logic                    PIX_VALID,
    output logic                    PIX_READY,
    output logic                    HDMI_DE,
    output logic                    HDMI_HSYNC,
    output logic                    HDMI_VSYNC,
    output logic [DATA_WIDTH-1:0]   HDMI_DATA,
    output logic                    FRAME_START,
    output logic                    UNDERFLOW,
    output logic                    BUSY
);

    state_e                 state_q, state_d;
    logic                   hpol_q, hpol_d, vpol_q, vpol_d;
    logic                   de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic                   fs_q, fs_d, uf_q, uf_d, busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;

    logic                   busy_c, load_c, frame_end_c, active_c;
    logic                   h_last_c, v_last_c, hs_lvl_c, vs_lvl_c;
    logic [1:0]             h_region_c, v_region_c;
    logic [H_WIDTH-1:0]     h_cnt;
    logic [V_WIDTH-1:0]     v_cnt;
    logic [DATA_WIDTH-1:0]  pix_packed_c;

    assign busy_c      = (state_q != IDLE);
    assign frame_end_c = busy_c & h_last_c & v_last_c;
    // Lengths track the inputs while idle and are re-sampled only at frame wrap.
    assign load_c      = ~busy_c | frame_end_c;

    hdmi_timing_axis #(.W(H_WIDTH)) u_h_axis (
        .clk        (ACLK),
        .rst        (RST),
        .clr        (~busy_c),
        .load       (load_c),
        .advance    (busy_c),
        .len_active (H_ACTIVE),
        .len_fp     (H_FP),
        .len_sync   (H_SYNC),
        .len_bp     (H_BP),
        .cnt        (h_cnt),
        .region_c   (h_region_c),
        .last_c     (h_last_c)
    );

    hdmi_timing_axis #(.W(V_WIDTH)) u_v_axis (
        .clk        (ACLK),
        .rst        (RST),
        .clr        (~busy_c),
        .load       (load_c),
        .advance    (busy_c & h_last_c),
        .len_active (V_ACTIVE),
        .len_fp     (V_FP),
        .len_sync   (V_SYNC),
        .len_bp     (V_BP),
        .cnt        (v_cnt),
        .region_c   (v_region_c),
        .last_c     (v_last_c)
    );

    // Next state, pixel handshake, packing and next values of all registered outputs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (EN) state_d = RUN;
            RUN:     if (!EN) state_d = frame_end_c ? IDLE : DRAIN;
            DRAIN:   if (EN) state_d = RUN;
                     else if (frame_end_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        hpol_d = load_c ? HSYNC_POL : hpol_q;
        vpol_d = load_c ? VSYNC_POL : vpol_q;
        // Idle syncs follow the live polarity so the inactive level is right immediately.
        hs_lvl_c = busy_c ? hpol_q : HSYNC_POL;
        vs_lvl_c = busy_c ? vpol_q : VSYNC_POL;

        active_c = busy_c && (h_region_c == ACTIVE) && (v_region_c == ACTIVE);

        pix_packed_c = {
            pack_slot(SLOT_WIDTH'(PIX_DATA[3*COMP_WIDTH-1 -: COMP_WIDTH]), COMP_WIDTH),
            pack_slot(SLOT_WIDTH'(PIX_DATA[2*COMP_WIDTH-1 -: COMP_WIDTH]), COMP_WIDTH),
            pack_slot(SLOT_WIDTH'(PIX_DATA[COMP_WIDTH-1 -: COMP_WIDTH]),   COMP_WIDTH)
        };

        de_d    = active_c;
        data_d  = (active_c && PIX_VALID) ? pix_packed_c : '0;
        uf_d    = active_c && !PIX_VALID;
        hsync_d = (busy_c && (h_region_c == SYNC)) ? hs_lvl_c : ~hs_lvl_c;
        vsync_d = (busy_c && (v_region_c == SYNC)) ? vs_lvl_c : ~vs_lvl_c;
        fs_d    = busy_c && (h_cnt == '0) && (v_cnt == '0);
        busy_d  = (state_d != IDLE);
    end

    // State, latched polarities and registered video outputs.
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            hpol_q  <= 1'b0;
            vpol_q  <= 1'b0;
            de_q    <= 1'b0;
            data_q  <= '0;
            uf_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hpol_q  <= hpol_d;
            vpol_q  <= vpol_d;
            de_q    <= de_d;
            data_q  <= data_d;
            uf_q    <= uf_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    assign PIX_READY   = active_c;
    assign HDMI_DE     = de_q;
    assign HDMI_HSYNC  = hsync_q;
    assign HDMI_VSYNC  = vsync_q;
    assign HDMI_DATA   = data_q;
    assign FRAME_START = fs_q;
    assign UNDERFLOW   = uf_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_hdmi_video_out.sv
// Scoreboard bench for hdmi_video_out: 8-bit and 12-bit instances share all controls.
module tb_hdmi_video_out;

    logic        ACLK = 1'b0;
    logic        RST, EN, HSYNC_POL, VSYNC_POL, PIX_VALID;
    logic [11:0] H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP;
    logic [23:0] pix8;
    logic [35:0] pix12;

    logic        rdy8, de8, hs8, vs8, fs8, uf8, busy8;
    logic [35:0] data8;
    logic        rdy12, de12, hs12, vs12, fs12, uf12, busy12;
    logic [35:0] data12;

    always #5 ACLK = ~ACLK;

    hdmi_video_out #(.COMP_WIDTH(8), .H_WIDTH(12), .V_WIDTH(12)) dut8 (
        .ACLK(ACLK), .RST(RST), .EN(EN),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL),
        .PIX_DATA(pix8), .PIX_VALID(PIX_VALID), .PIX_READY(rdy8),
        .HDMI_DE(de8), .HDMI_HSYNC(hs8), .HDMI_VSYNC(vs8), .HDMI_DATA(data8),
        .FRAME_START(fs8), .UNDERFLOW(uf8), .BUSY(busy8)
    );

    hdmi_video_out #(.COMP_WIDTH(12), .H_WIDTH(12), .V_WIDTH(12)) dut12 (
        .ACLK(ACLK), .RST(RST), .EN(EN),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL),
        .PIX_DATA(pix12), .PIX_VALID(PIX_VALID), .PIX_READY(rdy12),
        .HDMI_DE(de12), .HDMI_HSYNC(hs12), .HDMI_VSYNC(vs12), .HDMI_DATA(data12),
        .FRAME_START(fs12), .UNDERFLOW(uf12), .BUSY(busy12)
    );

    typedef struct {
        logic        de, hs, vs, fs, uf, busy;
        logic [35:0] d8, d12;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Pixel stream and hand-packed expected words.
    logic [23:0] tbl8  [4] = '{24'hABCDEF, 24'h123456, 24'h00FF80, 24'h7E0155};
    logic [35:0] exp8  [4] = '{36'hAB0CD0EF0, 36'h120340560, 36'h000FF0800, 36'h7E0010550};
    logic [35:0] tbl12 [4] = '{36'hFFF001800, 36'h123456789, 36'h000FFF00A, 36'hABCDEF012};

    // Reference timing model state.
    int   m_busy = 0;
    int   m_pos  = 0;
    int   mh[4];
    int   mv[4];
    logic m_hp, m_vp;
    int   pi = 0;
    int   drop_left = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk36(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic latch_timing();
        mh[0] = int'(H_ACTIVE); mh[1] = int'(H_FP); mh[2] = int'(H_SYNC); mh[3] = int'(H_BP);
        mv[0] = int'(V_ACTIVE); mv[1] = int'(V_FP); mv[2] = int'(V_SYNC); mv[3] = int'(V_BP);
        m_hp = HSYNC_POL;
        m_vp = VSYNC_POL;
    endtask

    // One clock: drive the source, predict the outputs after the next edge, push.
    task automatic cycle();
        exp_t e;
        int   ht, vt, h, v, hs_lo, vs_lo;
        logic act, fend;
        e = '{de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0, uf: 1'b0, busy: 1'b0, d8: '0, d12: '0};
        act = 1'b0;
        ht = mh[0] + mh[1] + mh[2] + mh[3] + 4;
        vt = mv[0] + mv[1] + mv[2] + mv[3] + 4;
        h  = m_pos % ht;
        v  = m_pos / ht;
        if (m_busy != 0 && !RST) act = (h <= mh[0]) && (v <= mv[0]);

        PIX_VALID = 1'b1;
        if (act && drop_left > 0) begin
            PIX_VALID = 1'b0;
            drop_left--;
        end
        pix8  = tbl8[pi];
        pix12 = tbl12[pi];
        #1;
        chk1("pix_ready8", rdy8, act);
        chk1("pix_ready12", rdy12, act);

        if (RST) begin
            chk1("rst_de", de8, 1'b0);
            chk1("rst_hsync", hs8, 1'b0);
            chk1("rst_vsync", vs8, 1'b0);
            chk36("rst_data", data8, 36'h0);
            chk1("rst_busy", busy8, 1'b0);
            m_busy = 0;
            m_pos  = 0;
        end else if (m_busy == 0) begin
            e.hs = ~HSYNC_POL;
            e.vs = ~VSYNC_POL;
            if (EN) begin
                m_busy = 1;
                m_pos  = 0;
                latch_timing();
            end
            e.busy = (m_busy != 0);
        end else begin
            hs_lo = mh[0] + mh[1] + 2;
            vs_lo = mv[0] + mv[1] + 2;
            e.de = act;
            e.uf = act && !PIX_VALID;
            if (act && PIX_VALID) begin
                e.d8  = exp8[pi];
                e.d12 = tbl12[pi];
                pi = (pi + 1) % 4;
            end
            e.hs = (h >= hs_lo && h <= hs_lo + mh[2]) ? m_hp : ~m_hp;
            e.vs = (v >= vs_lo && v <= vs_lo + mv[2]) ? m_vp : ~m_vp;
            e.fs = (m_pos == 0);
            fend = (m_pos == ht * vt - 1);
            if (!EN && fend) m_busy = 0;
            if (fend) begin
                m_pos = 0;
                if (m_busy != 0) latch_timing();
            end else begin
                m_pos++;
            end
            e.busy = (m_busy != 0);
        end
        q.push_back(e);
        @(negedge ACLK);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to(input int p);
        int guard;
        guard = 0;
        while (!(m_busy != 0 && m_pos == p) && guard < 1000) begin
            cycle();
            guard++;
        end
        if (guard >= 1000) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_to_timeout: position %0d not reached", p);
        end
    endtask

    // Monitor: compares both instances against the oldest prediction after each edge.
    initial begin
        exp_t r;
        forever begin
            @(posedge ACLK);
            #1;
            if (q.size() > 0) begin
                r = q.pop_front();
                chk1("de8", de8, r.de);
                chk1("hsync8", hs8, r.hs);
                chk1("vsync8", vs8, r.vs);
                chk1("frame_start8", fs8, r.fs);
                chk1("underflow8", uf8, r.uf);
                chk1("busy8", busy8, r.busy);
                chk36("data8", data8, r.d8);
                chk1("de12", de12, r.de);
                chk1("hsync12", hs12, r.hs);
                chk1("vsync12", vs12, r.vs);
                chk1("frame_start12", fs12, r.fs);
                chk1("underflow12", uf12, r.uf);
                chk1("busy12", busy12, r.busy);
                chk36("data12", data12, r.d12);
            end
        end
    end

    initial begin
        RST = 1'b1; EN = 1'b0; HSYNC_POL = 1'b1; VSYNC_POL = 1'b1; PIX_VALID = 1'b0;
        H_ACTIVE = 12'd3; H_FP = 12'd0; H_SYNC = 12'd1; H_BP = 12'd0;
        V_ACTIVE = 12'd2; V_FP = 12'd0; V_SYNC = 12'd0; V_BP = 12'd0;
        pix8 = '0; pix12 = '0;
        latch_timing();
        @(negedge ACLK);

        run(3);                               // held in reset
        RST = 1'b0; run(3);                   // idle, syncs inactive
        EN = 1'b1;  run(100);                 // two full 48-cycle frames
        run_to(1); drop_left = 2; run(48);    // two starved active pixels
        run_to(9); EN = 1'b0; run(60);        // stop mid line 1, frame completes then idle
        EN = 1'b1;  run(50);
        run_to(9); EN = 1'b0; run_to(30);     // re-raise during drain
        EN = 1'b1;  run(40);
        run_to(20); H_ACTIVE = 12'd5; run(120);            // new line length from next frame
        run_to(5); HSYNC_POL = 1'b0; VSYNC_POL = 1'b0; run(130);
        run_to(2); RST = 1'b1; run(2);        // async reset mid active line
        RST = 1'b0; run(70);

        @(negedge ACLK);
        chk36("queue_drained", 36'(q.size()), 36'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hdmi_video_out.md
Name: hdmi_video_out

Overview:
- Parametrised HDMI pixel output stage: programmable video timing generator plus pixel-stream sink driving the external HDMI transmitter's parallel interface (DE/HSYNC/VSYNC/36-bit DATA).
- Sits between the frame-fetch pixel FIFO (valid/ready stream) and the HDMI pins.
- Generalises the fixed 8-bit-per-component path: supports 8/10/12-bit components, per-frame timing reprogramming, sync polarity control, clean start/stop and underflow reporting.

Parameters:
- COMP_WIDTH, 8, bits per colour component; legal 8, 10, 12.
- H_WIDTH, 12, width of horizontal timing fields and counter.
- V_WIDTH, 12, width of vertical timing fields and counter.

Ports:
- ACLK  in  1  pixel clock.
- RST  in  1  asynchronous reset, active-high.
- EN  in  1  run request (level).
- H_ACTIVE, H_FP, H_SYNC, H_BP  in  H_WIDTH each  horizontal region lengths, value = cycles-1.
- V_ACTIVE, V_FP, V_SYNC, V_BP  in  V_WIDTH each  vertical region lengths, value = lines-1.
- HSYNC_POL, VSYNC_POL  in  1 each  1 = active-high sync.
- PIX_DATA  in  3*COMP_WIDTH  {R,G,B}, R in MSBs.
- PIX_VALID  in  1  pixel available.
- PIX_READY  out  1  pixel consumed this cycle.
- HDMI_DE, HDMI_HSYNC, HDMI_VSYNC  out  1 each  registered video controls.
- HDMI_DATA  out  36  registered pixel data.
- FRAME_START  out  1  one-cycle pulse at first cycle of each frame.
- UNDERFLOW  out  1  one-cycle pulse per starved active pixel.
- BUSY  out  1  high when not IDLE.

Behaviour:
- Reset (async, RST=1): state IDLE, counters 0, all outputs 0.
- State machine:
  - IDLE -> RUN when EN=1; latches all timing/polarity inputs; h=v=0.
  - RUN -> DRAIN when EN=0.
  - DRAIN -> RUN if EN returns before end of frame; otherwise DRAIN -> IDLE after last cycle of last back-porch line.
- Timing inputs are relatched at every frame wrap (h and v both at last count). Mid-frame input changes have no effect.
- Horizontal order: active, front porch, sync, back porch. H_TOTAL = sum of (field+1). Same order vertically.
- h wraps to 0 at H_TOTAL-1; v increments on h wrap and wraps at V_TOTAL-1.
- Active = h in active region AND v in active region AND state != IDLE.
- PIX_READY = active (combinational from counters). Transfer occurs when PIX_READY & PIX_VALID.
- Output latency: 1 cycle. Registered DE = active of previous cycle. HDMI_DATA = transferred pixel in that cycle; all zeros outside active.
- Underflow: PIX_READY & ~PIX_VALID gives UNDERFLOW pulse 1 cycle later, aligned with DE. DE stays 1 with black data (0). Timing is never stalled.
- HSYNC asserted during the h sync region, on all lines. VSYNC asserted for the whole duration of v sync lines, from h=0.
- Output level = POL when asserted, ~POL otherwise.
- In IDLE, sync outputs drive the inactive level (first clock after reset onward), DE=0, DATA=0, PIX_READY=0.
- FRAME_START pulses registered, coincident with first DE of the frame (h=v=0).
- Data packing: 12-bit slots, R->[35:24], G->[23:12], B->[11:0]. Each component is MSB-aligned in its slot; unused LSBs are 0. For COMP_WIDTH=8: [27:24], [15:12], [3:0] = 0.
- EN=0 during active video in RUN: the frame completes normally, no truncation.
- BUSY = state != IDLE.

Decomposition:
- Package hdmi_video_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - region enum {ACTIVE, FP, SYNC, BP};
  - SLOT_WIDTH=12 constant;
  - pack function (component -> MSB-aligned slot).
- Sub-module hdmi_timing_axis: one counter + region decoder, parametrised by width, with advance input, wrap output and latched region lengths. Instantiated twice: h advances every cycle, v on h wrap.

Test Plan:
- Small mode (H 3/0/1/0 -> total 8; V 2/0/0/0 -> 6 lines), COMP_WIDTH=8, PIX_VALID always 1, POL=1:
  - per line, DE high exactly 4 cycles, HSYNC high 2 cycles starting 1 cycle after DE falls;
  - VSYNC high for 8 cycles on line 4;
  - FRAME_START period 48 cycles.
- Pixel 0xAB_CD_EF, COMP_WIDTH=8 -> HDMI_DATA = 0xAB0_CD0_EF0. COMP_WIDTH=12, pixel 0xFFF_001_800 -> HDMI_DATA = 0xFFF001800.
- PIX_VALID dropped for 2 active cycles -> 2 UNDERFLOW pulses aligned with DE; DATA=0 on those cycles; HSYNC/VSYNC timing unchanged.
- EN deasserted mid active line 1 -> frame finishes all 48 cycles, then BUSY=0, DE=0. EN re-raised during DRAIN -> next frame starts seamlessly.
- Change H_ACTIVE mid-frame -> current frame unchanged, new line length from next FRAME_START. POL=0 -> syncs idle high, pulse low.
- RST asserted mid active line -> all outputs 0 immediately (async). After release with EN=1, frame restarts at h=v=0 with FRAME_START.
